compute_cluster_seq: RTL and testbench
======================================

Name: compute_cluster_seq

Overview:
- Job-level sequencer for the compute cluster memory subsystem (IFM/filter SRAMs feeding the compute cluster's ping-pong chunk buffers).
- On a start command it streams N IFM chunks and their per-compute-unit filter chunks from SRAM into the chunk write buffer, then launches compute on the read buffer.
- Loading of chunk k+1 overlaps compute of chunk k.
- Signals job done and advances the accumulation output buffer.

Parameters:
- WR_DAT_CYC_NUM, 4: beats per chunk write (one bus word per beat).
- SRAM_IFM_NUM, 8: IFM chunk slots in IFM SRAM.
- SRAM_FILTER_NUM, 32: filter chunk slots in filter SRAM.
- COMPUTE_UNIT_NUM, 4: compute units; each gets its own filter chunk.
- OUTPUT_BUF_NUM, 2: accumulation output buffers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  job start pulse; ignored while busy_o=1
- cfg_chunk_num_i  in  $clog2(SRAM_IFM_NUM)+1  IFM chunks in job (0..SRAM_IFM_NUM); sampled on accepted start
- cfg_fil_base_i  in  $clog2(SRAM_FILTER_NUM)  first filter SRAM slot; sampled on accepted start
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end
- ifm_chunk_wr_valid_o  out  1  IFM chunk beat write strobe
- ifm_chunk_wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  IFM beat index
- ifm_sram_rd_count_o  out  $clog2(SRAM_IFM_NUM)  IFM SRAM chunk slot
- ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o  out  1 each  chunk buffer being loaded (always equal)
- ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o  out  1 each  chunk buffer being computed (always equal)
- fil_chunk_wr_valid_o  out  1  filter beat write strobe
- fil_chunk_wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  filter beat index
- fil_chunk_cu_wr_sel_o  out  COMPUTE_UNIT_NUM  one-hot target compute unit
- fil_sram_rd_count_o  out  $clog2(SRAM_FILTER_NUM)  filter SRAM chunk slot
- run_valid_o  out  1  compute enable
- total_chunk_start_o  out  1  one-cycle compute-start pulse
- total_chunk_end_i  in  1  compute unit finished current chunk (pulse)
- acc_buf_sel_o  out  $clog2(OUTPUT_BUF_NUM)  accumulation buffer select

Behaviour:
- Reset: all outputs 0, including acc_buf_sel_o=0 and both sel pairs=0. Both FSMs go IDLE. Buffer-full flags full[1:0]=0. A reset mid-job aborts the job with no done_o.
- SRAM read is same-cycle. Read counts and beat counts are driven combinationally from registered state, aligned with the write strobes.
- Start accepted when start_i=1 and busy_o=0. busy_o rises the next cycle. load_idx, run_idx and wsel/rsel are cleared. fil_ptr is loaded with cfg_fil_base_i.
- cfg_chunk_num_i=0: done_o pulses the cycle after start; busy_o stays 0 (no strobes).
- Loader FSM:
  - L_IDLE → L_IFM on accepted start.
  - L_IFM: ifm_chunk_wr_valid_o=1 for WR_DAT_CYC_NUM cycles; count 0..N-1; ifm_sram_rd_count_o=load_idx. Then → L_FIL with cu=0.
  - L_FIL: for each cu 0..COMPUTE_UNIT_NUM-1, fil_chunk_wr_valid_o=1 for WR_DAT_CYC_NUM beats. fil_chunk_cu_wr_sel_o=1<<cu; fil_sram_rd_count_o=fil_ptr. fil_ptr increments after each CU's last beat, wrapping modulo SRAM_FILTER_NUM.
  - After the last filter beat: full[wsel] set, wsel toggles, load_idx++.
  - If load_idx==chunk_num → L_IDLE. Else if full[new wsel] → L_WAIT, else → L_IFM.
  - L_WAIT → L_IFM the cycle after full[wsel] reads 0.
  - Load time per chunk: WR_DAT_CYC_NUM*(1+COMPUTE_UNIT_NUM) cycles.
- Compute FSM:
  - C_IDLE → C_START when busy and full[rsel]=1.
  - C_START: total_chunk_start_o=1 and run_valid_o=1 for one cycle → C_RUN.
  - C_RUN: run_valid_o=1 until total_chunk_end_i=1. In that cycle: clear full[rsel], toggle rsel, run_idx++.
  - Then, if run_idx==chunk_num: done_o pulses the next cycle, busy_o falls the same cycle, acc_buf_sel_o increments (wrapping at OUTPUT_BUF_NUM-1→0) → C_IDLE.
  - Otherwise → C_IDLE, which re-arms on full[rsel].
  - total_chunk_end_i outside C_RUN is ignored.
- Simultaneous clear/set: set and clear never target the same buffer in one cycle. Flags are registered, so a buffer freed in cycle t is writable from t+1.
- No beat strobes occur while busy_o=0. A wr_sel buffer is never loaded while its full flag is 1.

Test Plan:
- Reset with rst_i=0 mid-L_FIL → all outputs 0 immediately (async); after release, start_i with cfg_chunk_num_i=1 runs a clean job.
- chunk_num=1, COMPUTE_UNIT_NUM=4, WR_DAT_CYC_NUM=4, fil_base=5:
  - 4 IFM beats (count 0..3, rd_count 0).
  - 16 filter beats with cu_wr_sel 0001,0010,0100,1000 and fil_sram_rd_count 5,6,7,8.
  - total_chunk_start_o one cycle after the load completes.
  - end pulse → done_o the next cycle; acc_buf_sel_o 0→1.
- chunk_num=3, end delayed 100 cycles per chunk → chunk 1 load overlaps chunk 0 run. Loader enters L_WAIT on chunk 2 until chunk 0 end. rd_sel sequence 0,1,0; wr_sel 0,1,0.
- fil_base=30, chunk_num=2 → fil_sram_rd_count 30,31,0,1,2,3,4,5 (wrap).
- start_i while busy → ignored, no config change. cfg_chunk_num_i=0 → done_o 1 cycle after start, no strobes.
- Two back-to-back jobs → acc_buf_sel_o 0→1→0; total_chunk_end_i injected in C_IDLE → no effect.

Source files
------------

// File: rtl/compute_cluster_seq.sv
// Job sequencer: streams IFM and per-compute-unit filter chunks into a ping-pong
// chunk buffer while the other half is being computed, then signals job done.
module compute_cluster_seq #(
  parameter int WR_DAT_CYC_NUM   = 4,
  parameter int SRAM_IFM_NUM     = 8,
  parameter int SRAM_FILTER_NUM  = 32,
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int OUTPUT_BUF_NUM   = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [$clog2(SRAM_IFM_NUM):0]       cfg_chunk_num_i,
  input  logic [$clog2(SRAM_FILTER_NUM)-1:0]  cfg_fil_base_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                ifm_chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   ifm_chunk_wr_count_o,
  output logic [$clog2(SRAM_IFM_NUM)-1:0]     ifm_sram_rd_count_o,
  output logic                                ifm_chunk_wr_sel_o,
  output logic                                fil_chunk_wr_sel_o,
  output logic                                ifm_chunk_rd_sel_o,
  output logic                                fil_chunk_rd_sel_o,
  output logic                                fil_chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   fil_chunk_wr_count_o,
  output logic [COMPUTE_UNIT_NUM-1:0]         fil_chunk_cu_wr_sel_o,
  output logic [$clog2(SRAM_FILTER_NUM)-1:0]  fil_sram_rd_count_o,
  output logic                                run_valid_o,
  output logic                                total_chunk_start_o,
  input  logic                                total_chunk_end_i,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   acc_buf_sel_o
);

  localparam int CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int IFM_W = $clog2(SRAM_IFM_NUM);
  localparam int CHN_W = IFM_W + 1;
  localparam int FIL_W = $clog2(SRAM_FILTER_NUM);
  localparam int CU_W  = $clog2(COMPUTE_UNIT_NUM);
  localparam int ACC_W = $clog2(OUTPUT_BUF_NUM);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(WR_DAT_CYC_NUM - 1);
  localparam logic [CU_W-1:0]  CU_LAST   = CU_W'(COMPUTE_UNIT_NUM - 1);
  localparam logic [FIL_W-1:0] FIL_LAST  = FIL_W'(SRAM_FILTER_NUM - 1);
  localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(OUTPUT_BUF_NUM - 1);

  typedef enum logic [1:0] {L_IDLE, L_IFM, L_FIL, L_WAIT} lstate_t;
  typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} cstate_t;

  lstate_t            lstate_reg, lstate_next;
  cstate_t            cstate_reg, cstate_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [CHN_W-1:0]   chunk_num_reg, chunk_num_next;
  logic [CHN_W-1:0]   load_idx_reg, load_idx_next;
  logic [CHN_W-1:0]   run_idx_reg, run_idx_next;
  logic [FIL_W-1:0]   fil_ptr_reg, fil_ptr_next;
  logic [CNT_W-1:0]   beat_reg, beat_next;
  logic [CU_W-1:0]    cu_reg, cu_next;
  logic               wsel_reg, wsel_next;
  logic               rsel_reg, rsel_next;
  logic [1:0]         full_reg, full_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic               set_full, clr_full;
  logic               start_acc;

  assign start_acc = start_i && !busy_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lstate_reg    <= L_IDLE;
      cstate_reg    <= C_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      chunk_num_reg <= '0;
      load_idx_reg  <= '0;
      run_idx_reg   <= '0;
      fil_ptr_reg   <= '0;
      beat_reg      <= '0;
      cu_reg        <= '0;
      wsel_reg      <= 1'b0;
      rsel_reg      <= 1'b0;
      full_reg      <= '0;
      acc_reg       <= '0;
    end else begin
      lstate_reg    <= lstate_next;
      cstate_reg    <= cstate_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      chunk_num_reg <= chunk_num_next;
      load_idx_reg  <= load_idx_next;
      run_idx_reg   <= run_idx_next;
      fil_ptr_reg   <= fil_ptr_next;
      beat_reg      <= beat_next;
      cu_reg        <= cu_next;
      wsel_reg      <= wsel_next;
      rsel_reg      <= rsel_next;
      full_reg      <= full_next;
      acc_reg       <= acc_next;
    end
  end

  always_comb begin
    lstate_next    = lstate_reg;
    cstate_next    = cstate_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    chunk_num_next = chunk_num_reg;
    load_idx_next  = load_idx_reg;
    run_idx_next   = run_idx_reg;
    fil_ptr_next   = fil_ptr_reg;
    beat_next      = beat_reg;
    cu_next        = cu_reg;
    wsel_next      = wsel_reg;
    rsel_next      = rsel_reg;
    acc_next       = acc_reg;
    set_full       = 1'b0;
    clr_full       = 1'b0;

    if (start_acc) begin
      chunk_num_next = cfg_chunk_num_i;
      fil_ptr_next   = cfg_fil_base_i;
      load_idx_next  = '0;
      run_idx_next   = '0;
      wsel_next      = 1'b0;
      rsel_next      = 1'b0;
      beat_next      = '0;
      cu_next        = '0;
      // An empty job completes immediately without ever raising busy.
      if (cfg_chunk_num_i == '0) begin
        done_next = 1'b1;
      end else begin
        busy_next   = 1'b1;
        lstate_next = L_IFM;
      end
    end

    case (lstate_reg)
      L_IFM: begin
        beat_next = beat_reg + CNT_W'(1);
        if (beat_reg == BEAT_LAST) begin
          beat_next   = '0;
          cu_next     = '0;
          lstate_next = L_FIL;
        end
      end
      L_FIL: begin
        beat_next = beat_reg + CNT_W'(1);
        if (beat_reg == BEAT_LAST) begin
          beat_next    = '0;
          fil_ptr_next = (fil_ptr_reg == FIL_LAST) ? '0 : fil_ptr_reg + FIL_W'(1);
          cu_next      = cu_reg + CU_W'(1);
          if (cu_reg == CU_LAST) begin
            cu_next       = '0;
            set_full      = 1'b1;
            wsel_next     = ~wsel_reg;
            load_idx_next = load_idx_reg + CHN_W'(1);
            if (load_idx_reg + CHN_W'(1) == chunk_num_reg)
              lstate_next = L_IDLE;
            else if (full_reg[~wsel_reg])
              lstate_next = L_WAIT;
            else
              lstate_next = L_IFM;
          end
        end
      end
      L_WAIT: begin
        if (!full_reg[wsel_reg])
          lstate_next = L_IFM;
      end
      default: ;
    endcase

    case (cstate_reg)
      C_IDLE: begin
        if (busy_reg && full_reg[rsel_reg])
          cstate_next = C_START;
      end
      C_START: cstate_next = C_RUN;
      C_RUN: begin
        if (total_chunk_end_i) begin
          clr_full     = 1'b1;
          rsel_next    = ~rsel_reg;
          run_idx_next = run_idx_reg + CHN_W'(1);
          cstate_next  = C_IDLE;
          if (run_idx_reg + CHN_W'(1) == chunk_num_reg) begin
            done_next = 1'b1;
            busy_next = 1'b0;
            acc_next  = (acc_reg == ACC_LAST) ? '0 : acc_reg + ACC_W'(1);
          end
        end
      end
      default: cstate_next = C_IDLE;
    endcase
  end

  // Loader and compute always address opposite halves, so set and clear never collide.
  always_comb begin
    full_next = full_reg;
    if (set_full) full_next[wsel_reg] = 1'b1;
    if (clr_full) full_next[rsel_reg] = 1'b0;
  end

  assign busy_o               = busy_reg;
  assign done_o               = done_reg;
  assign ifm_chunk_wr_valid_o = (lstate_reg == L_IFM);
  assign fil_chunk_wr_valid_o = (lstate_reg == L_FIL);
  assign ifm_chunk_wr_count_o = ifm_chunk_wr_valid_o ? beat_reg : '0;
  assign ifm_sram_rd_count_o  = ifm_chunk_wr_valid_o ? load_idx_reg[IFM_W-1:0] : '0;
  assign fil_chunk_wr_count_o = fil_chunk_wr_valid_o ? beat_reg : '0;
  assign fil_sram_rd_count_o  = fil_chunk_wr_valid_o ? fil_ptr_reg : '0;
  assign ifm_chunk_wr_sel_o   = wsel_reg;
  assign fil_chunk_wr_sel_o   = wsel_reg;
  assign ifm_chunk_rd_sel_o   = rsel_reg;
  assign fil_chunk_rd_sel_o   = rsel_reg;
  assign run_valid_o          = (cstate_reg == C_START) || (cstate_reg == C_RUN);
  assign total_chunk_start_o  = (cstate_reg == C_START);
  assign acc_buf_sel_o        = acc_reg;

  for (genvar gi = 0; gi < COMPUTE_UNIT_NUM; gi++) begin : g_cu_sel
    assign fil_chunk_cu_wr_sel_o[gi] = fil_chunk_wr_valid_o && (cu_reg == CU_W'(gi));
  end

endmodule

// File: tb/tb_compute_cluster_seq.sv
// Randomized bench for compute_cluster_seq: a cycle-schedule model of each job
// predicts every output cycle by cycle.
module tb_compute_cluster_seq;
  localparam int WR   = 4;
  localparam int CU   = 4;
  localparam int NFIL = 32;
  localparam int LOAD = WR * (1 + CU);

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] cfg_chunk_num_i;
  logic [4:0] cfg_fil_base_i;
  logic       busy_o, done_o;
  logic       ifm_chunk_wr_valid_o;
  logic [1:0] ifm_chunk_wr_count_o;
  logic [2:0] ifm_sram_rd_count_o;
  logic       ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o;
  logic       ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o;
  logic       fil_chunk_wr_valid_o;
  logic [1:0] fil_chunk_wr_count_o;
  logic [3:0] fil_chunk_cu_wr_sel_o;
  logic [4:0] fil_sram_rd_count_o;
  logic       run_valid_o, total_chunk_start_o;
  logic       total_chunk_end_i;
  logic [0:0] acc_buf_sel_o;

  compute_cluster_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cfg_chunk_num_i(cfg_chunk_num_i), .cfg_fil_base_i(cfg_fil_base_i),
    .busy_o(busy_o), .done_o(done_o),
    .ifm_chunk_wr_valid_o(ifm_chunk_wr_valid_o), .ifm_chunk_wr_count_o(ifm_chunk_wr_count_o),
    .ifm_sram_rd_count_o(ifm_sram_rd_count_o),
    .ifm_chunk_wr_sel_o(ifm_chunk_wr_sel_o), .fil_chunk_wr_sel_o(fil_chunk_wr_sel_o),
    .ifm_chunk_rd_sel_o(ifm_chunk_rd_sel_o), .fil_chunk_rd_sel_o(fil_chunk_rd_sel_o),
    .fil_chunk_wr_valid_o(fil_chunk_wr_valid_o), .fil_chunk_wr_count_o(fil_chunk_wr_count_o),
    .fil_chunk_cu_wr_sel_o(fil_chunk_cu_wr_sel_o), .fil_sram_rd_count_o(fil_sram_rd_count_o),
    .run_valid_o(run_valid_o), .total_chunk_start_o(total_chunk_start_o),
    .total_chunk_end_i(total_chunk_end_i), .acc_buf_sel_o(acc_buf_sel_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_model = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {5'b0, busy_o, done_o, ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o, ifm_sram_rd_count_o,
            ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o, fil_chunk_wr_valid_o, fil_chunk_wr_count_o,
            fil_chunk_cu_wr_sel_o, fil_sram_rd_count_o, ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o,
            run_valid_o, total_chunk_start_o, acc_buf_sel_o};
  endfunction

  // Job schedule (cycle 1 = first cycle after the accepted start edge):
  // L[k] first IFM beat, S[k] compute-start pulse, E[k] cycle the end pulse is driven.
  task automatic run_job(input int n, input int base, input int dmin, input int dmax,
                         input bit noise, input string name);
    int L[8], S[8], E[8];
    int done_c, busy_end, last_c, acc_before;
    acc_before = acc_model;
    for (int k = 0; k < n; k++) begin
      if (k == 0) L[k] = 1;
      else if (k == 1 || E[k-2] <= L[k-1] + LOAD - 2) L[k] = L[k-1] + LOAD;
      else L[k] = E[k-2] + 2;
      S[k] = L[k] + LOAD + 1;
      if (k > 0 && E[k-1] + 2 > S[k]) S[k] = E[k-1] + 2;
      E[k] = S[k] + $urandom_range(dmin, dmax);
    end
    if (n == 0) begin done_c = 1; busy_end = 0; end
    else begin done_c = E[n-1] + 1; busy_end = E[n-1]; end
    last_c = done_c + 3;

    @(negedge clk_i);
    start_i = 1'b1;
    cfg_chunk_num_i = 4'(n);
    cfg_fil_base_i = 5'(base);
    total_chunk_end_i = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      logic e_iv, e_fv, e_ws, e_st, e_run, e_rs, e_acc;
      logic [1:0] e_icnt, e_fcnt;
      logic [2:0] e_ird;
      logic [3:0] e_cu;
      logic [4:0] e_frd;
      logic [31:0] exp_v, act_v;
      bit in_run, is_end;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      total_chunk_end_i = 1'b0;
      e_iv = 0; e_fv = 0; e_ws = 0; e_st = 0; e_run = 0; e_rs = 0;
      e_icnt = 0; e_fcnt = 0; e_ird = 0; e_cu = 0; e_frd = 0;
      in_run = 0; is_end = 0;
      for (int k = 0; k < n; k++) begin
        if (c >= L[k] && c <= L[k] + WR - 1) begin
          e_iv = 1; e_icnt = 2'(c - L[k]); e_ird = 3'(k); e_ws = k[0];
        end
        if (c >= L[k] + WR && c <= L[k] + LOAD - 1) begin
          int off;
          off = c - L[k] - WR;
          e_fv = 1; e_fcnt = 2'(off % WR); e_cu = 4'(1 << (off / WR));
          e_frd = 5'((base + k * CU + off / WR) % NFIL); e_ws = k[0];
        end
        if (c == S[k]) e_st = 1;
        if (c >= S[k] && c <= E[k]) begin e_run = 1; e_rs = k[0]; in_run = 1; end
        if (c == E[k]) is_end = 1;
      end
      if (is_end) total_chunk_end_i = 1'b1;
      else if (noise && !in_run && $urandom_range(0, 7) == 0) total_chunk_end_i = 1'b1;
      if (noise && c <= busy_end && $urandom_range(0, 5) == 0) begin
        start_i = 1'b1;
        cfg_chunk_num_i = 4'($urandom_range(0, 8));
        cfg_fil_base_i = 5'($urandom_range(0, 31));
      end
      e_acc = (n > 0 && c >= done_c) ? 1'((acc_before + 1) % 2) : 1'(acc_before);
      @(negedge clk_i);
      exp_v = {5'b0, 1'(n > 0 && c <= busy_end), 1'(c == done_c), e_iv, e_icnt, e_ird,
               e_ws & (e_iv | e_fv), e_ws & (e_iv | e_fv), e_fv, e_fcnt, e_cu, e_frd,
               e_rs, e_rs, e_run, e_st, e_acc};
      act_v = {5'b0, busy_o, done_o, ifm_chunk_wr_valid_o,
               e_iv ? ifm_chunk_wr_count_o : 2'b0, e_iv ? ifm_sram_rd_count_o : 3'b0,
               (e_iv | e_fv) & ifm_chunk_wr_sel_o, (e_iv | e_fv) & fil_chunk_wr_sel_o,
               fil_chunk_wr_valid_o, e_fv ? fil_chunk_wr_count_o : 2'b0,
               e_fv ? fil_chunk_cu_wr_sel_o : 4'b0, e_fv ? fil_sram_rd_count_o : 5'b0,
               e_run & ifm_chunk_rd_sel_o, e_run & fil_chunk_rd_sel_o,
               run_valid_o, total_chunk_start_o, acc_buf_sel_o};
      check_val($sformatf("%s_n%0d_c%0d", name, n, c), act_v, exp_v);
    end
    if (n > 0) acc_model = (acc_model + 1) % 2;
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    total_chunk_end_i = 1'b0;
    cfg_chunk_num_i = '0;
    cfg_fil_base_i = '0;
    repeat (3) @(negedge clk_i);
    check_val("reset_outs", all_outs(), 32'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_job(1, 5, 3, 3, 0, "single");
    run_job(3, $urandom_range(0, 31), 100, 100, 0, "overlap");
    run_job(2, 30, 1, 10, 1, "wrap");
    run_job(0, 7, 1, 1, 1, "empty");
    for (int i = 0; i < 6; i++)
      run_job((i == 0) ? 8 : $urandom_range(1, 8), $urandom_range(0, 31), 1, 40, 1, "rand");

    // Abort a job in the middle of filter loading with an asynchronous reset.
    @(negedge clk_i);
    start_i = 1'b1;
    cfg_chunk_num_i = 4'd1;
    cfg_fil_base_i = 5'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #2;
    check_val("pre_rst_fil_valid", {31'b0, fil_chunk_wr_valid_o}, 32'h1);
    #1 rst_i = 1'b0;
    #1 check_val("async_rst_outs", all_outs(), 32'h0);
    acc_model = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    run_job(1, 9, 2, 2, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
